// File: rtl/serial_subtractor.sv
// Purpose: computes a - b - bin over WIDTH/BITS_PER_CYCLE steps, LSB chunk first, borrow kept in a register.
// Latency: N = WIDTH/BITS_PER_CYCLE edges from the accepting edge to the done pulse; one result every N+1 cycles back-to-back.
// Backpressure: start is only sampled in IDLE or the DONE cycle; a start during RUN is dropped, never queued.
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               br_q, br_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   chunk_w;
    logic               br_c;
    logic [WIDTH-1:0]   part_step;

    // A new operation can only be taken while idle or in the single done cycle.
    assign accept    = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // Ripple the full-subtractor equations across the low chunk of the operand registers.
    always_comb begin
        br_c    = br_q;
        chunk_w = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            chunk_w[i] = a_sh_q[i] ^ b_sh_q[i] ^ br_c;
            br_c       = (~a_sh_q[i] & b_sh_q[i]) | (~(a_sh_q[i] ^ b_sh_q[i]) & br_c);
        end
        // New chunk enters from the MSB side so the finished word lands aligned after N steps.
        part_step = (part_q >> BITS_PER_CYCLE) | (chunk_w << (WIDTH - BITS_PER_CYCLE));
    end

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load on acceptance, step while running, publish results on the final step only.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        part_d  = part_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            a_sh_d  = a_i;
            b_sh_d  = b_i;
            br_d    = bin_i;
            part_d  = '0;
            cnt_d   = '0;
            // Sign bits are kept aside because the shift registers lose them during the run.
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = b_i[WIDTH-1];
        end else if (state_q == RUN) begin
            a_sh_d = a_sh_q >> BITS_PER_CYCLE;
            b_sh_d = b_sh_q >> BITS_PER_CYCLE;
            part_d = part_step;
            br_d   = br_c;
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
                diff_d = part_step;
                bout_d = br_c;
                ovf_d  = (a_msb_q ^ b_msb_q) & (part_step[WIDTH-1] ^ a_msb_q);
                zero_d = (part_step == '0);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers; reset clears everything so an aborted run leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            part_q  <= part_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: three instances (8/1, 4/1, 4/2) checked against an arithmetic model.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on done is bounded; a missed done counts as a failure.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s8 = 1'b0, bi8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bz8, dn8, bo8, ov8, zr8;
    logic [7:0] df8;

    logic       s41 = 1'b0, bi41 = 1'b0;
    logic [3:0] a41 = '0, b41 = '0;
    logic       bz41, dn41, bo41, ov41, zr41;
    logic [3:0] df41;

    logic       s42 = 1'b0, bi42 = 1'b0;
    logic [3:0] a42 = '0, b42 = '0;
    logic       bz42, dn42, bo42, ov42, zr42;
    logic [3:0] df42;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start_i(s8), .a_i(a8), .b_i(b8), .bin_i(bi8),
        .busy_o(bz8), .done_o(dn8), .diff_o(df8), .bout_o(bo8), .ovf_o(ov8), .zero_o(zr8));

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(1)) u41 (
        .clk(clk), .rst_n(rst_n), .start_i(s41), .a_i(a41), .b_i(b41), .bin_i(bi41),
        .busy_o(bz41), .done_o(dn41), .diff_o(df41), .bout_o(bo41), .ovf_o(ov41), .zero_o(zr41));

    serial_subtractor #(.WIDTH(4), .BITS_PER_CYCLE(2)) u42 (
        .clk(clk), .rst_n(rst_n), .start_i(s42), .a_i(a42), .b_i(b42), .bin_i(bi42),
        .busy_o(bz42), .done_o(dn42), .diff_o(df42), .bout_o(bo42), .ovf_o(ov42), .zero_o(zr42));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       zr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
        s8 = 1'b0; s41 = 1'b0; s42 = 1'b0;
        case (sel)
            0: begin s8 = st; a8 = a; b8 = b; bi8 = bin; end
            1: begin s41 = st; a41 = a[3:0]; b41 = b[3:0]; bi41 = bin; end
            default: begin s42 = st; a42 = a[3:0]; b42 = b[3:0]; bi42 = bin; end
        endcase
    endtask

    task automatic rd(input int sel, output logic busy, output logic done, output logic [7:0] diff,
                      output logic bout, output logic ovf, output logic zero);
        case (sel)
            0: begin busy = bz8; done = dn8; diff = df8; bout = bo8; ovf = ov8; zero = zr8; end
            1: begin busy = bz41; done = dn41; diff = {4'h0, df41}; bout = bo41; ovf = ov41; zero = zr41; end
            default: begin busy = bz42; done = dn42; diff = {4'h0, df42}; bout = bo42; ovf = ov42; zero = zr42; end
        endcase
    endtask

    // Reference: plain integer subtraction, then the flag rules applied to the resulting word.
    task automatic model(input int w, input int a, input int b, input int bin,
                         output logic [7:0] d, output logic bo, output logic ov, output logic zr);
        int full, di, sa, sb, sd;
        full = a - b - bin;
        di   = full & ((1 << w) - 1);
        sa   = (a >> (w - 1)) & 1;
        sb   = (b >> (w - 1)) & 1;
        sd   = (di >> (w - 1)) & 1;
        d    = di[7:0];
        bo   = (a < b + bin);
        ov   = (sa != sb) && (sd != sa);
        zr   = (di == 0);
    endtask

    // One operation: checks busy span, latency, and the done pulse width; returns the results.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input string tag, output logic [7:0] d, output logic bo, output logic ov,
                         output logic zr);
        int n, lat, bcnt;
        logic busy, done, both, got;
        n = (sel == 0) ? 8 : (sel == 1) ? 4 : 2;
        @(negedge clk);
        drive(sel, 1'b1, a, b, bin);
        @(negedge clk);
        // Operands wander after acceptance; the result must not care.
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        rd(sel, busy, done, d, bo, ov, zr);
        bcnt = busy ? 1 : 0;
        both = busy & done;
        lat  = 0;
        got  = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            rd(sel, busy, done, d, bo, ov, zr);
            if (busy && done) both = 1'b1;
            if (done) got = 1'b1;
            else if (busy) bcnt++;
        end
        chk({tag, " done seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(n));
        chk({tag, " busy cycles"}, 32'(bcnt), 32'(n));
        chk({tag, " busy&done"}, 32'(both), 32'd0);
        @(negedge clk);
        rd(sel, busy, done, d, bo, ov, zr);
        chk({tag, " done pulse 1 cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] d, ed;
        logic bo, ov, zr, ebo, eov, ezr, busy, done;
        int lat, dcount, t, k;
        logic [7:0] oa[4];
        logic [7:0] ob[4];
        logic       obi[4];

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

        // Reset held with random, active-looking inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
            s41 = 1'b1; s42 = 1'b1;
        end
        @(negedge clk);
        chk("reset busy", 32'(bz8), 32'd0);
        chk("reset done", 32'(dn8), 32'd0);
        chk("reset outs", 32'({df8, bo8, ov8, zr8}), 32'd0);
        chk("reset 4-bit outs", 32'({bz41, dn41, df41, bz42, dn42, df42}), 32'd0);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post-reset idle", 32'({bz8, dn8, df8, bz41, bz42}), 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            do_op(0, vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), d, bo, ov, zr);
            chk($sformatf("vec%0d diff", i), 32'(d), 32'(vecs[i].d));
            chk($sformatf("vec%0d bout", i), 32'(bo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d ovf", i), 32'(ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d zero", i), 32'(zr), 32'(vecs[i].zr));
        end

        // Start pulsed mid-run must be ignored.
        @(negedge clk);
        drive(0, 1'b1, 8'h10, 8'h0F, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 8'h10, 8'h0F, 1'b1);
        lat = 0; dcount = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) drive(0, 1'b1, 8'hFF, 8'h00, 1'b0);
            else drive(0, 1'b0, 8'hFF, 8'h00, 1'b0);
            if (dn8) begin
                dcount++;
                if (dcount == 1) begin
                    lat = i; d = df8; bo = bo8; zr = zr8;
                end
            end
        end
        chk("midrun done count", 32'(dcount), 32'd1);
        chk("midrun latency", 32'(lat), 32'd8);
        chk("midrun diff", 32'(d), 32'h00);
        chk("midrun zero", 32'(zr), 32'd1);
        chk("midrun bout", 32'(bo), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(0, 1'b1, 8'h5A, 8'h33, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort outs zero", 32'({bz8, dn8, df8, bo8, ov8, zr8}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dn8 || bz8) dcount++;
        end
        chk("abort no done", 32'(dcount), 32'd0);

        // Back-to-back with start held high: a result every 9 cycles.
        oa = '{8'h05, 8'h00, 8'hC3, 8'h80};
        ob = '{8'h03, 8'h01, 8'h3C, 8'h7F};
        obi = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        drive(0, 1'b1, oa[0], ob[0], obi[0]);
        t = 0; k = 0;
        while (k < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (dn8) begin
                model(8, int'(oa[k]), int'(ob[k]), int'(obi[k]), ed, ebo, eov, ezr);
                chk($sformatf("b2b%0d period", k), 32'(t), 32'(9 * (k + 1)));
                chk($sformatf("b2b%0d result", k), 32'({df8, bo8, ov8, zr8}), 32'({ed, ebo, eov, ezr}));
                k++;
                if (k < 4) drive(0, 1'b1, oa[k], ob[k], obi[k]);
                else drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
            end
        end
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("b2b all dones", 32'(k), 32'd4);
        @(negedge clk);

        // Random 8-bit operations against the model.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            do_op(0, ra, rb, rbi, "rnd", d, bo, ov, zr);
            model(8, int'(ra), int'(rb), int'(rbi), ed, ebo, eov, ezr);
            chk($sformatf("rnd %h-%h-%b", ra, rb, rbi), 32'({d, bo, ov, zr}), 32'({ed, ebo, eov, ezr}));
        end

        // Exhaustive 4-bit, one and two bits per step.
        for (int sel = 1; sel <= 2; sel++) begin
            for (int c = 0; c < 512; c++) begin
                int ea, eb, ebi;
                ea = c & 15; eb = (c >> 4) & 15; ebi = (c >> 8) & 1;
                do_op(sel, 8'(ea), 8'(eb), 1'(ebi), $sformatf("x%0d", sel), d, bo, ov, zr);
                model(4, ea, eb, ebi, ed, ebo, eov, ezr);
                chk($sformatf("x%0d %0d-%0d-%0d", sel, ea, eb, ebi), 32'({d, bo, ov, zr}),
                    32'({ed, ebo, eov, ezr}));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
